// File: rtl/sdram_host_arbiter.sv
// Purpose : two-client (A/B) single-outstanding arbiter in front of an SDRAM controller.
// Latency : req->ack/host cmd 1 cycle from IDLE; host_rd_valid->rvalid 1 cycle.
// Backpres: clients hold req until ack; nothing issues while host_busy=1 or a command is in flight.
//
// Ports:
//   clk_sys, rst                        clock (rising edge), async active-high reset
//   a_*/b_* req, we, addr, wdata        client request side (inputs)
//   a_*/b_* ack, rvalid, rdata          client response side (outputs, registered)
//   host_wr_req, host_rd_req            one-cycle command pulses to the controller
//   host_addr, host_data_in             command address / write data, held until next grant
//   host_busy, host_rd_valid,
//   host_data_out                       controller status and read return
//   timeout_err                         sticky abort flag
module sdram_host_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk_sys,
    input  logic        rst,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [23:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_ack,
    output logic        a_rvalid,
    output logic [15:0] a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [23:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_ack,
    output logic        b_rvalid,
    output logic [15:0] b_rdata,

    output logic        host_wr_req,
    output logic        host_rd_req,
    output logic [23:0] host_addr,
    output logic [15:0] host_data_in,
    input  logic        host_busy,
    input  logic        host_rd_valid,
    input  logic [15:0] host_data_out,

    output logic        timeout_err
);

    // Counter is at least 8 bits and wide enough to hold TIMEOUT.
    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;
    // The counter reads 0 on the first cycle of a wait state, so the
    // TIMEOUT-th cycle spent there is the one where it equals TIMEOUT-1.
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [15:0]   ABORT_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state;
    logic          cur_we;     // granted command is a write
    logic          cur_b;      // granted port is B
    logic          last_b;     // last grant went to B; reset value 0 makes B win first
    logic          rd_done;    // read data already returned for this command
    logic [CW-1:0] cnt;

    logic          pick_b;
    logic          sel_we;
    logic [23:0]   sel_addr;
    logic [15:0]   sel_wdata;
    logic          cnt_expired;
    logic          rd_capture;
    logic          rd_abort;
    logic [15:0]   rd_word;

    always_comb begin
        // B wins when alone, when round robin is off, or when A was served last.
        pick_b    = b_req && (!a_req || (ROUND_ROBIN == 0) || !last_b);
        sel_we    = pick_b ? b_we    : a_we;
        sel_addr  = pick_b ? b_addr  : a_addr;
        sel_wdata = pick_b ? b_wdata : a_wdata;

        cnt_expired = (cnt == CNT_LAST);

        // Only the first host_rd_valid of a read in WAIT_DONE is delivered;
        // returns during writes or in other states are dropped.
        rd_capture = (state == WAIT_DONE) && !cur_we && host_rd_valid && !rd_done;

        // A read that times out before any data arrived still owes its client
        // one rvalid, carrying the abort marker.
        rd_abort = !cur_we && cnt_expired &&
                   (((state == WAIT_BUSY) && !host_busy) ||
                    ((state == WAIT_DONE) && !rd_done && !host_rd_valid));

        rd_word = rd_capture ? host_data_out : ABORT_DATA;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cur_we       <= 1'b0;
            cur_b        <= 1'b0;
            last_b       <= 1'b0;
            rd_done      <= 1'b0;
            cnt          <= '0;
            a_ack        <= 1'b0;
            b_ack        <= 1'b0;
            a_rvalid     <= 1'b0;
            b_rvalid     <= 1'b0;
            a_rdata      <= 16'h0000;
            b_rdata      <= 16'h0000;
            host_wr_req  <= 1'b0;
            host_rd_req  <= 1'b0;
            host_addr    <= 24'h000000;
            host_data_in <= 16'h0000;
            timeout_err  <= 1'b0;
        end else begin
            // All pulse outputs default low; they are set for exactly one cycle below.
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
            host_wr_req <= 1'b0;
            host_rd_req <= 1'b0;

            case (state)
                IDLE: begin
                    // Requests are sampled live: one dropped before this point is never served.
                    if (!host_busy && (a_req || b_req)) begin
                        cur_b        <= pick_b;
                        last_b       <= pick_b;
                        cur_we       <= sel_we;
                        host_addr    <= sel_addr;
                        host_data_in <= sel_wdata;
                        // Command pulse and ack are registered here so they are
                        // both high during the single ISSUE cycle.
                        host_wr_req  <= sel_we;
                        host_rd_req  <= !sel_we;
                        a_ack        <= !pick_b;
                        b_ack        <= pick_b;
                        rd_done      <= 1'b0;
                        state        <= ISSUE;
                    end
                end

                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end

                WAIT_BUSY: begin
                    if (host_busy) begin
                        cnt   <= '0;
                        state <= WAIT_DONE;
                    end else if (cnt_expired) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_DONE: begin
                    if (cur_we) begin
                        if (!host_busy) begin
                            state <= IDLE;
                        end else if (cnt_expired) begin
                            timeout_err <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        if (rd_capture) begin
                            rd_done <= 1'b1;
                        end
                        // Data returning in the same cycle busy drops completes at once.
                        if ((rd_done || host_rd_valid) && !host_busy) begin
                            state <= IDLE;
                        end else if (cnt_expired) begin
                            timeout_err <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // Read return path: only the granted port's rdata/rvalid change.
            if (rd_capture || rd_abort) begin
                if (cur_b) begin
                    b_rdata  <= rd_word;
                    b_rvalid <= 1'b1;
                end else begin
                    a_rdata  <= rd_word;
                    a_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule
